// File: rtl/qea_host_ctrl.sv
// Host-side job sequencer for the QEA core: loads context and initial state,
// starts the core, watches for completion or a hang, then streams the final state out.
module qea_host_ctrl #(
    parameter int PE_NUM_WIDTH            = 2,
    parameter int PE_NUM                  = 4,
    parameter int MAX_QBIT_WIDTH          = 6,
    parameter int STATE_DATA_WIDTH        = 64,
    parameter int STATE_ADDR_WIDTH        = 16,
    parameter int GATE_CONTEXT_DATA_WIDTH = 64,
    parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
    parameter int RD_LATENCY              = 1,
    parameter int TIMEOUT_WIDTH           = 32
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  i_cmd_valid,
    output logic                                  o_cmd_ready,
    input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]    i_ins_num,
    input  logic [MAX_QBIT_WIDTH-1:0]             i_qbit_num,
    input  logic [TIMEOUT_WIDTH-1:0]              i_timeout,
    input  logic                                  i_ctx_valid,
    output logic                                  o_ctx_ready,
    input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]    i_ctx_data,
    input  logic                                  i_st_valid,
    output logic                                  o_st_ready,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]    i_st_data,
    output logic                                  o_rd_valid,
    input  logic                                  i_rd_ready,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]    o_rd_data,
    output logic                                  o_qea_start,
    output logic [MAX_QBIT_WIDTH-1:0]             o_qea_qbit_num,
    output logic                                  o_ctx_en,
    output logic                                  o_ctx_wea,
    output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]    o_ctx_addr,
    output logic [GATE_CONTEXT_DATA_WIDTH-1:0]    o_ctx_data,
    output logic                                  o_state_ena,
    output logic                                  o_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]           o_state_addra,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]    o_state_dina,
    input  logic                                  i_qea_complete,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]    i_qea_state_dout,
    output logic                                  o_busy,
    output logic                                  o_done,
    output logic                                  o_error,
    output logic [TIMEOUT_WIDTH-1:0]              o_cycle_count
);

    localparam int ROW_W  = STATE_ADDR_WIDTH + 1;
    localparam int DATA_W = PE_NUM * STATE_DATA_WIDTH;
    localparam int LAT_W  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_CTX, S_LOAD_ST, S_START, S_RUN, S_RD_ISSUE, S_RD_WAIT, S_RD_OUT
    } state_t;

    state_t                               state_reg, state_next;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   ins_num_reg, ins_num_next;
    logic [MAX_QBIT_WIDTH-1:0]            qbit_reg, qbit_next;
    logic [TIMEOUT_WIDTH-1:0]             timeout_reg, timeout_next;
    logic [ROW_W-1:0]                     rows_reg, rows_next;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   ctx_cnt_reg, ctx_cnt_next;
    logic [ROW_W-1:0]                     row_cnt_reg, row_cnt_next;
    logic [TIMEOUT_WIDTH-1:0]             cycle_cnt_reg, cycle_cnt_next;
    logic                                 first_run_reg, first_run_next;
    logic [LAT_W-1:0]                     lat_cnt_reg, lat_cnt_next;
    logic [DATA_W-1:0]                    rd_data_reg, rd_data_next;
    logic                                 error_reg, error_next;
    logic                                 done_reg, done_next;
    logic                                 ctx_en_reg, ctx_en_next;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   ctx_addr_reg, ctx_addr_next;
    logic [GATE_CONTEXT_DATA_WIDTH-1:0]   ctx_data_reg, ctx_data_next;
    logic                                 st_we_reg, st_we_next;
    logic [STATE_ADDR_WIDTH-1:0]          st_addr_reg, st_addr_next;
    logic [DATA_W-1:0]                    st_dina_reg, st_dina_next;

    logic                                 cmd_bad;
    logic [MAX_QBIT_WIDTH-1:0]            row_shift;
    logic [ROW_W-1:0]                     rows_calc;
    logic [TIMEOUT_WIDTH-1:0]             cyc_inc;

    assign cmd_bad   = (i_ins_num == '0)
                    || (int'(i_qbit_num) < PE_NUM_WIDTH)
                    || (int'(i_qbit_num) > STATE_ADDR_WIDTH + PE_NUM_WIDTH);
    assign row_shift = i_qbit_num - MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
    // One spare bit so a full 2^STATE_ADDR_WIDTH-row job is still representable.
    assign rows_calc = ROW_W'(1) << row_shift;
    assign cyc_inc   = (&cycle_cnt_reg) ? cycle_cnt_reg : cycle_cnt_reg + 1'b1;

    always_comb begin
        state_next     = state_reg;
        ins_num_next   = ins_num_reg;
        qbit_next      = qbit_reg;
        timeout_next   = timeout_reg;
        rows_next      = rows_reg;
        ctx_cnt_next   = ctx_cnt_reg;
        row_cnt_next   = row_cnt_reg;
        cycle_cnt_next = cycle_cnt_reg;
        first_run_next = first_run_reg;
        lat_cnt_next   = lat_cnt_reg;
        rd_data_next   = rd_data_reg;
        error_next     = error_reg;
        done_next      = 1'b0;
        ctx_en_next    = 1'b0;
        ctx_addr_next  = ctx_addr_reg;
        ctx_data_next  = ctx_data_reg;
        st_we_next     = 1'b0;
        st_addr_next   = st_addr_reg;
        st_dina_next   = st_dina_reg;

        case (state_reg)
            S_IDLE: begin
                if (i_cmd_valid) begin
                    error_next = 1'b0;
                    if (cmd_bad) begin
                        error_next = 1'b1;
                    end else begin
                        ins_num_next = i_ins_num;
                        qbit_next    = i_qbit_num;
                        timeout_next = i_timeout;
                        rows_next    = rows_calc;
                        ctx_cnt_next = '0;
                        state_next   = S_LOAD_CTX;
                    end
                end
            end
            S_LOAD_CTX: begin
                if (i_ctx_valid) begin
                    ctx_en_next   = 1'b1;
                    ctx_addr_next = ctx_cnt_reg;
                    ctx_data_next = i_ctx_data;
                    if (ctx_cnt_reg == ins_num_reg - 1'b1) begin
                        row_cnt_next = '0;
                        state_next   = S_LOAD_ST;
                    end else begin
                        ctx_cnt_next = ctx_cnt_reg + 1'b1;
                    end
                end
            end
            S_LOAD_ST: begin
                if (i_st_valid) begin
                    st_we_next   = 1'b1;
                    st_addr_next = row_cnt_reg[STATE_ADDR_WIDTH-1:0];
                    st_dina_next = i_st_data;
                    if (row_cnt_reg == rows_reg - 1'b1) begin
                        state_next = S_START;
                    end else begin
                        row_cnt_next = row_cnt_reg + 1'b1;
                    end
                end
            end
            S_START: begin
                cycle_cnt_next = '0;
                first_run_next = 1'b1;
                state_next     = S_RUN;
            end
            S_RUN: begin
                first_run_next = 1'b0;
                // A complete left over from a previous job is masked for one cycle.
                if (!first_run_reg && i_qea_complete) begin
                    row_cnt_next = '0;
                    state_next   = S_RD_ISSUE;
                end else begin
                    cycle_cnt_next = cyc_inc;
                    if ((timeout_reg != '0) && (cyc_inc >= timeout_reg)) begin
                        error_next = 1'b1;
                        state_next = S_IDLE;
                    end
                end
            end
            S_RD_ISSUE: begin
                lat_cnt_next = '0;
                state_next   = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (lat_cnt_reg == LAT_W'(RD_LATENCY - 1)) begin
                    rd_data_next = i_qea_state_dout;
                    state_next   = S_RD_OUT;
                end else begin
                    lat_cnt_next = lat_cnt_reg + 1'b1;
                end
            end
            S_RD_OUT: begin
                if (i_rd_ready) begin
                    if (row_cnt_reg == rows_reg - 1'b1) begin
                        done_next  = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        row_cnt_next = row_cnt_reg + 1'b1;
                        state_next   = S_RD_ISSUE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            ins_num_reg   <= '0;
            qbit_reg      <= '0;
            timeout_reg   <= '0;
            rows_reg      <= '0;
            ctx_cnt_reg   <= '0;
            row_cnt_reg   <= '0;
            cycle_cnt_reg <= '0;
            first_run_reg <= 1'b0;
            lat_cnt_reg   <= '0;
            rd_data_reg   <= '0;
            error_reg     <= 1'b0;
            done_reg      <= 1'b0;
            ctx_en_reg    <= 1'b0;
            ctx_addr_reg  <= '0;
            ctx_data_reg  <= '0;
            st_we_reg     <= 1'b0;
            st_addr_reg   <= '0;
            st_dina_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            ins_num_reg   <= ins_num_next;
            qbit_reg      <= qbit_next;
            timeout_reg   <= timeout_next;
            rows_reg      <= rows_next;
            ctx_cnt_reg   <= ctx_cnt_next;
            row_cnt_reg   <= row_cnt_next;
            cycle_cnt_reg <= cycle_cnt_next;
            first_run_reg <= first_run_next;
            lat_cnt_reg   <= lat_cnt_next;
            rd_data_reg   <= rd_data_next;
            error_reg     <= error_next;
            done_reg      <= done_next;
            ctx_en_reg    <= ctx_en_next;
            ctx_addr_reg  <= ctx_addr_next;
            ctx_data_reg  <= ctx_data_next;
            st_we_reg     <= st_we_next;
            st_addr_reg   <= st_addr_next;
            st_dina_reg   <= st_dina_next;
        end
    end

    // Read issue shares the STATE RAM port with the registered load writes.
    assign o_state_ena    = st_we_reg | (state_reg == S_RD_ISSUE);
    assign o_state_wea    = st_we_reg;
    assign o_state_addra  = (state_reg == S_RD_ISSUE) ? row_cnt_reg[STATE_ADDR_WIDTH-1:0]
                                                      : st_addr_reg;
    assign o_state_dina   = st_dina_reg;
    assign o_ctx_en       = ctx_en_reg;
    assign o_ctx_wea      = ctx_en_reg;
    assign o_ctx_addr     = ctx_addr_reg;
    assign o_ctx_data     = ctx_data_reg;
    assign o_cmd_ready    = (state_reg == S_IDLE);
    assign o_busy         = (state_reg != S_IDLE);
    assign o_ctx_ready    = (state_reg == S_LOAD_CTX);
    assign o_st_ready     = (state_reg == S_LOAD_ST);
    assign o_qea_start    = (state_reg == S_START);
    assign o_rd_valid     = (state_reg == S_RD_OUT);
    assign o_rd_data      = rd_data_reg;
    assign o_qea_qbit_num = qbit_reg;
    assign o_done         = done_reg;
    assign o_error        = error_reg;
    assign o_cycle_count  = cycle_cnt_reg;

endmodule
